// File: rtl/decoder_stream_if.sv
// rtl/decoder_stream_if.sv - valid/ready bundle for the streaming binary decoder
//
// Purpose: groups the input (index) channel and the output (decoded vector)
// channel of decoder_stream.
// Ports (signals):
//   in_valid/in_ready/in_idx/in_mode     input channel, producer -> decoder
//   out_valid/out_ready/out_vec/out_err  output channel, decoder -> consumer
// Modports:
//   slave  - the decoder side
//   master - the environment side (producer and consumer)
interface decoder_stream_if #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_idx;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_vec;
  logic                 out_err;

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_err
  );

  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_err
  );
endinterface

// File: rtl/decoder_stream.sv
// rtl/decoder_stream.sv - registered, flow-controlled one-hot/thermometer decoder
//
// Purpose: accepts a binary index per input beat and emits a one-hot
// (in_mode=0) or thermometer (in_mode=1) vector per output beat. Indices
// >= OUT_WIDTH yield a zero vector with out_err set, and are counted in a
// saturating error counter. Two entries of storage (output + skid register)
// give full throughput while keeping in_ready free of any out_ready path.
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   bus        decoder_stream_if.slave (input and output channels)
//   err_clr    synchronous clear of err_count (wins over increment)
//   err_count  saturating count of accepted out-of-range beats
module decoder_stream #(
  parameter int IN_WIDTH      = 3,
  parameter int OUT_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decoder_stream_if.slave          bus,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  // One extra bit so OUT_WIDTH == 2**IN_WIDTH is representable in compares.
  localparam int IW1 = IN_WIDTH + 1;

  logic [OUT_WIDTH-1:0] out_vec_q;
  logic                 out_err_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] skid_vec_q;
  logic                 skid_err_q;
  logic                 skid_valid_q;

  logic [OUT_WIDTH-1:0] dec_vec;
  logic                 dec_err;
  logic                 in_fire;
  logic                 out_free;

  always_comb begin
    dec_vec = '0;
    dec_err = ({1'b0, bus.in_idx} >= IW1'(OUT_WIDTH));
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (bus.in_mode)
        dec_vec[k] = (IW1'(k) <= {1'b0, bus.in_idx});
      else
        dec_vec[k] = (IW1'(k) == {1'b0, bus.in_idx});
    end
    if (dec_err)
      dec_vec = '0;
  end

  // in_ready is just "skid empty", a register output.
  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_err   = out_err_q;

  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_vec_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_vec_q   <= '0;
      skid_err_q   <= 1'b0;
    end else if (out_free) begin
      // Skid beat is older than anything on the input, so it goes first.
      // A full skid also means in_ready was low, so no input is taken here.
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_vec_q    <= skid_vec_q;
        out_err_q    <= skid_err_q;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_valid_q <= 1'b1;
        out_vec_q   <= dec_vec;
        out_err_q   <= dec_err;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      // Output is held under backpressure: park the new beat.
      skid_valid_q <= 1'b1;
      skid_vec_q   <= dec_vec;
      skid_err_q   <= dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (in_fire && dec_err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_decoder_stream.sv
// tb/tb_decoder_stream.sv - directed self-checking bench for decoder_stream
module tb_decoder_stream;

  logic clk;
  logic rst_n;
  logic a_clr;
  logic b_clr;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  int   pass_cnt;
  int   total_cnt;

  decoder_stream_if #(.IN_WIDTH(3), .OUT_WIDTH(8)) a_if ();
  decoder_stream_if #(.IN_WIDTH(3), .OUT_WIDTH(5)) b_if ();

  decoder_stream #(.IN_WIDTH(3), .OUT_WIDTH(8), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .err_clr(a_clr), .err_count(a_cnt)
  );

  decoder_stream #(.IN_WIDTH(3), .OUT_WIDTH(5), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .err_clr(b_clr), .err_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_clr = 1'b0; b_clr = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_idx = '0; a_if.in_mode = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_idx = '0; b_if.in_mode = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({a_if.out_valid, a_if.in_ready, a_if.out_err} !== 3'b010)
      $display("FAIL reset_flags: valid/ready/err=%b required 010",
               {a_if.out_valid, a_if.in_ready, a_if.out_err});
    else pass_cnt++;
    total_cnt++;
    if (a_if.out_vec !== 8'h00) $display("FAIL reset_vec: got %h required 00", a_if.out_vec);
    else pass_cnt++;
    total_cnt++;
    if (a_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d required 0", a_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_onehot_sweep();
    a_if.out_ready = 1'b1;
    a_if.in_mode   = 1'b0;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_if.in_idx = 3'(i);
      step();
      total_cnt++;
      if ({a_if.out_valid, a_if.out_err, a_if.out_vec} !== {2'b10, 8'(1 << i)})
        $display("FAIL sweep[%0d]: valid=%b err=%b vec=%h required valid=1 err=0 vec=%h",
                 i, a_if.out_valid, a_if.out_err, a_if.out_vec, 8'(1 << i));
      else pass_cnt++;
    end
    a_if.in_valid = 1'b0;
    step();
    total_cnt++;
    if (a_if.out_valid !== 1'b0) $display("FAIL sweep_drain: valid=%b required 0", a_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_thermometer();
    int         idx_tab [3];
    logic [7:0] exp_tab [3];
    idx_tab = '{0, 3, 7};
    exp_tab = '{8'h01, 8'h0F, 8'hFF};
    a_if.in_mode  = 1'b1;
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.in_idx = 3'(idx_tab[i]);
      step();
      total_cnt++;
      if ({a_if.out_valid, a_if.out_err, a_if.out_vec} !== {2'b10, exp_tab[i]})
        $display("FAIL therm[%0d]: valid=%b err=%b vec=%h required valid=1 err=0 vec=%h",
                 idx_tab[i], a_if.out_valid, a_if.out_err, a_if.out_vec, exp_tab[i]);
      else pass_cnt++;
    end
    a_if.in_valid = 1'b0;
    a_if.in_mode  = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    int         idx_tab [3];
    logic [4:0] vec_tab [3];
    logic       err_tab [3];
    idx_tab = '{5, 7, 2};
    vec_tab = '{5'h00, 5'h00, 5'h04};
    err_tab = '{1'b1, 1'b1, 1'b0};
    b_if.out_ready = 1'b1;
    b_if.in_mode   = 1'b0;
    b_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_if.in_idx = 3'(idx_tab[i]);
      step();
      total_cnt++;
      if ({b_if.out_valid, b_if.out_err, b_if.out_vec} !== {1'b1, err_tab[i], vec_tab[i]})
        $display("FAIL range[%0d]: valid=%b err=%b vec=%h required valid=1 err=%b vec=%h",
                 idx_tab[i], b_if.out_valid, b_if.out_err, b_if.out_vec, err_tab[i], vec_tab[i]);
      else pass_cnt++;
    end
    b_if.in_valid = 1'b0;
    step();
    total_cnt++;
    if (b_cnt !== 2'd2) $display("FAIL range_errcnt: got %0d required 2", b_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_tab [4];
    logic       rdy_tab [4];
    a_if.in_mode   = 1'b0;
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_idx    = 3'd1;
    step();                       // idx1 into output register
    a_if.in_idx = 3'd2;
    step();                       // idx2 into skid register
    a_if.in_idx = 3'd3;           // held by producer until accepted
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({a_if.in_ready, a_if.out_valid, a_if.out_vec} !== {2'b01, 8'h02})
        $display("FAIL stall[%0d]: ready=%b valid=%b vec=%h required ready=0 valid=1 vec=02",
                 c, a_if.in_ready, a_if.out_valid, a_if.out_vec);
      else pass_cnt++;
      if (c < 2) step();
    end
    a_if.out_ready = 1'b1;
    exp_tab = '{8'h04, 8'h08, 8'h10, 8'h00};
    rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 1) a_if.in_idx = 3'd4;
      if (c == 2) a_if.in_valid = 1'b0;
      total_cnt++;
      if ({a_if.in_ready, a_if.out_valid, a_if.out_vec} !==
          {rdy_tab[c], (c < 3), (c < 3) ? exp_tab[c] : a_if.out_vec})
        $display("FAIL release[%0d]: ready=%b valid=%b vec=%h required ready=%b valid=%b vec=%h",
                 c, a_if.in_ready, a_if.out_valid, a_if.out_vec, rdy_tab[c], (c < 3), exp_tab[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] exp_tab [5];
    exp_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    total_cnt++;
    if (b_cnt !== 2'd0) $display("FAIL clr_plain: got %0d required 0", b_cnt);
    else pass_cnt++;
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_if.in_idx = 3'(5 + (i % 3));
      step();
      total_cnt++;
      if (b_cnt !== exp_tab[i]) $display("FAIL sat[%0d]: got %0d required %0d", i, b_cnt, exp_tab[i]);
      else pass_cnt++;
    end
    b_if.in_idx = 3'd6;
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    b_if.in_valid = 1'b0;
    total_cnt++;
    if (b_cnt !== 2'd0) $display("FAIL clr_vs_inc: got %0d required 0", b_cnt);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_stream();
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    b_if.in_idx    = 3'd6;
    step();
    b_if.in_idx = 3'd1;
    step();
    b_if.in_valid = 1'b0;
    total_cnt++;
    if ({b_if.in_ready, b_if.out_valid, b_cnt} !== {2'b01, 2'd1})
      $display("FAIL mid_full: ready=%b valid=%b errcnt=%0d required ready=0 valid=1 errcnt=1",
               b_if.in_ready, b_if.out_valid, b_cnt);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({b_if.in_ready, b_if.out_valid, b_cnt} !== {2'b10, 2'd0})
      $display("FAIL mid_reset: ready=%b valid=%b errcnt=%0d required ready=1 valid=0 errcnt=0",
               b_if.in_ready, b_if.out_valid, b_cnt);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    b_if.out_ready = 1'b1;
    step();
    step();
    total_cnt++;
    if (b_if.out_valid !== 1'b0) $display("FAIL mid_stale: valid=%b required 0", b_if.out_valid);
    else pass_cnt++;
    b_if.in_valid = 1'b1;
    b_if.in_idx   = 3'd3;
    step();
    b_if.in_valid = 1'b0;
    total_cnt++;
    if ({b_if.out_valid, b_if.out_err, b_if.out_vec} !== {2'b10, 5'h08})
      $display("FAIL mid_fresh: valid=%b err=%b vec=%h required valid=1 err=0 vec=08",
               b_if.out_valid, b_if.out_err, b_if.out_vec);
    else pass_cnt++;
    step();
    total_cnt++;
    if (b_if.out_valid !== 1'b0) $display("FAIL mid_dup: valid=%b required 0", b_if.out_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_onehot_sweep();
    test_thermometer();
    test_out_of_range();
    test_backpressure();
    test_saturation_clear();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
